// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan controller.
package seg_pkg;
  localparam int SEG_CODE_W = 5;
  localparam logic [SEG_CODE_W-1:0] SEG_BLANK_CODE = 5'h10;
  localparam int SEG_NUM_DIGITS_DEF = 8;
  localparam int SEG_REFRESH_DIV_DEF = 50000;
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: per-digit slot counter running 0..REFRESH_DIV-1 with start/last flags.
module seg_tick_gen import seg_pkg::*; #(
  parameter int REFRESH_DIV = SEG_REFRESH_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start,
  output logic slot_last
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] r_cnt;
  assign slot_start = r_cnt == '0;
  assign slot_last  = r_cnt == CW'(REFRESH_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= slot_last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment scan with frame-boundary display updates.
// Optional leading-zero blanking when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_scan_mux import seg_pkg::*; #(
  parameter int NUM_DIGITS  = SEG_NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = SEG_REFRESH_DIV_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic                    in_ready,
  output logic [SEG_CODE_W-1:0]   digit_code,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic w_slot_start, w_slot_last, w_load_disp, r_pend;
  logic [IW-1:0] r_idx;
  logic [W-1:0] r_pend_data, r_disp, w_disp_nxt;
  logic [NUM_DIGITS-1:0] r_pend_dp, r_dpm, w_dpm_nxt, w_blank;
  logic [3:0] w_nib;
  logic [SEG_CODE_W-1:0] r_code;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic r_dp_n, r_frame_done;

  seg_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_start(w_slot_start),
    .slot_last (w_slot_last)
  );

  assign in_ready   = 1'b1;
  assign digit_code = r_code;
  assign an_n       = r_an_n;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;
  // The frame_done cycle is the only point where the displayed word may change.
  assign w_load_disp = r_frame_done & (in_valid | r_pend);
  assign w_disp_nxt  = in_valid ? in_data : r_pend_data;
  assign w_dpm_nxt   = in_valid ? in_dp : r_pend_dp;
  assign w_nib       = r_disp[4*r_idx +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] r_blank, w_blank_nxt;
  logic w_sig;
  // Digit k is blanked when no digit at or above k is significant; digit 0 never blanks.
  always_comb begin
    w_sig = 1'b0;
    w_blank_nxt = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_sig = w_sig | (|w_disp_nxt[4*k +: 4]) | w_dpm_nxt[k];
      w_blank_nxt[k] = ~w_sig;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n)           r_blank <= ~NUM_DIGITS'(1);
    else if (w_load_disp) r_blank <= w_blank_nxt;
  assign w_blank = r_blank;
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_disp      <= '0;
      r_dpm       <= '0;
    end else begin
      if (w_load_disp) begin
        r_disp <= w_disp_nxt;
        r_dpm  <= w_dpm_nxt;
      end
      if (r_frame_done) r_pend <= 1'b0;
      else if (in_valid) begin
        r_pend      <= 1'b1;
        r_pend_data <= in_data;
        r_pend_dp   <= in_dp;
      end
    end

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_idx        <= '0;
      r_an_n       <= '1;
      r_code       <= SEG_BLANK_CODE;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      if (w_slot_last) r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
      r_an_n       <= w_slot_start ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_code       <= (w_slot_start | w_blank[r_idx]) ? SEG_BLANK_CODE : {1'b0, w_nib};
      r_dp_n       <= w_slot_start | ~r_dpm[r_idx];
      r_frame_done <= w_slot_last & (r_idx == IW'(NUM_DIGITS - 1));
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: table-driven frames plus randomized traffic against a timeline model.
module tb_seg_scan_mux;
  localparam int N = 8, RD = 4, FR = N * RD;
  logic clk = 1'b0, rst_n, in_valid, in_ready, dp_n, frame_done;
  logic [31:0] in_data;
  logic [7:0] in_dp, an_n;
  logic [4:0] digit_code;
  int n_vec = 0, n_err = 0;
  int m_k;
  logic [31:0] m_disp, m_pd;
  logic [7:0] m_dpm, m_pdp, e_an;
  logic m_pend, e_dpn, e_fd;
  logic [4:0] e_code;

  typedef struct {
    logic [31:0] data;
    logic [7:0] dp;
    logic decoy;
    logic bnd;
    logic [7:0][4:0] cb;
    logic [7:0][4:0] cp;
    logic [7:0] dpn;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_dp(in_dp),
    .in_ready(in_ready), .digit_code(digit_code), .an_n(an_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  function automatic logic [4:0] model_code(logic [31:0] d, logic [7:0] dp, int dig);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    int hi;
    hi = 0;
    for (int j = 0; j < N; j++) if (((d >> (4*j)) & 32'hF) != 0 || dp[j]) hi = j;
    if (dig > hi) return 5'h10;
`endif
    return {1'b0, 4'((d >> (4*dig)) & 32'hF)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic rn, logic v, logic [31:0] d, logic [7:0] dp);
    int p, dig;
    rst_n = rn; in_valid = v; in_data = d; in_dp = dp;
    @(posedge clk);
    if (!rn) begin
      m_k = 0; m_disp = 0; m_dpm = 0; m_pend = 0; m_pd = 0; m_pdp = 0;
      e_an = 8'hFF; e_code = 5'h10; e_dpn = 1'b1; e_fd = 1'b0;
    end else begin
      p = m_k;
      dig = (p / RD) % N;
      e_an   = (p % RD == 0) ? 8'hFF : ~(8'(1) << dig);
      e_code = (p % RD == 0) ? 5'h10 : model_code(m_disp, m_dpm, dig);
      e_dpn  = (p % RD == 0) ? 1'b1 : ~m_dpm[dig];
      e_fd   = (p % FR) == FR - 1;
      if (m_k > 0 && m_k % FR == 0) begin
        if (v) begin m_disp = d; m_dpm = dp; end
        else if (m_pend) begin m_disp = m_pd; m_dpm = m_pdp; end
        m_pend = 1'b0;
      end else if (v) begin
        m_pend = 1'b1; m_pd = d; m_pdp = dp;
      end
      m_k++;
    end
    #1;
    chk($sformatf("scan_step@%0d", m_k), {an_n, digit_code, dp_n, frame_done, in_ready},
        {e_an, e_code, e_dpn, e_fd, 1'b1});
  endtask

  initial begin
    vec_t t;
    logic [7:0][4:0] cap_code, exp_code;
    logic [7:0] cap_dpn;
    logic [63:0] cap_an;
    int cnt;
    tbl[0] = '{32'h89ABCDEF, 8'h00, 1'b0, 1'b0,
               {5'h08,5'h09,5'h0A,5'h0B,5'h0C,5'h0D,5'h0E,5'h0F},
               {5'h08,5'h09,5'h0A,5'h0B,5'h0C,5'h0D,5'h0E,5'h0F}, 8'hFF};
    tbl[1] = '{32'h22222222, 8'h00, 1'b1, 1'b0,
               {8{5'h02}}, {8{5'h02}}, 8'hFF};
    tbl[2] = '{32'h0000ABCD, 8'h00, 1'b0, 1'b1,
               {5'h10,5'h10,5'h10,5'h10,5'h0A,5'h0B,5'h0C,5'h0D},
               {5'h00,5'h00,5'h00,5'h00,5'h0A,5'h0B,5'h0C,5'h0D}, 8'hFF};
    tbl[3] = '{32'h00000305, 8'h10, 1'b0, 1'b0,
               {5'h10,5'h10,5'h10,5'h00,5'h00,5'h03,5'h00,5'h05},
               {5'h00,5'h00,5'h00,5'h00,5'h00,5'h03,5'h00,5'h05}, 8'hEF};
    tbl[4] = '{32'h00000000, 8'h00, 1'b0, 1'b0,
               {{7{5'h10}}, 5'h00}, {8{5'h00}}, 8'hFF};
    tbl[5] = '{32'hF0000000, 8'h81, 1'b0, 1'b0,
               {5'h0F, {7{5'h00}}}, {5'h0F, {7{5'h00}}}, 8'h7E};
    tbl[6] = '{32'h00000000, 8'h04, 1'b0, 1'b1,
               {{5{5'h10}}, {3{5'h00}}}, {8{5'h00}}, 8'hFB};

    repeat (3) step(1'b0, 1'b0, 32'h0, 8'h0);
    chk("reset_an", 64'(an_n), 64'hFF);
    chk("reset_code", 64'(digit_code), 64'h10);
    chk("reset_dpn", 64'(dp_n), 64'h1);
    chk("reset_fd", 64'(frame_done), 64'h0);
    chk("reset_ready", 64'(in_ready), 64'h1);
    cnt = 0;
    do begin step(1'b1, 1'b0, 32'h0, 8'h0); cnt++; end while (!frame_done && cnt < 100);
    chk("first_frame_done", 64'(cnt), 64'd32);

    foreach (tbl[i]) begin
      t = tbl[i];
      if (!t.bnd) begin
        repeat (4) step(1'b1, 1'b0, 32'h0, 8'h0);
        if (t.decoy) step(1'b1, 1'b1, 32'h11111111, 8'hFF);
        repeat (2) step(1'b1, 1'b0, 32'h0, 8'h0);
        step(1'b1, 1'b1, t.data, t.dp);
        cnt = 0;
        while (!e_fd && cnt < 2 * FR) begin step(1'b1, 1'b0, 32'h0, 8'h0); cnt++; end
      end
      cap_code = '0; cap_dpn = '0; cap_an = '0;
      for (int j = 0; j < FR; j++) begin
        if (t.bnd && j == 0) step(1'b1, 1'b1, t.data, t.dp);
        else step(1'b1, 1'b0, 32'h0, 8'h0);
        if (j % RD == 1) begin
          cap_code[j/RD] = digit_code;
          cap_dpn[j/RD] = dp_n;
          cap_an[8*(j/RD) +: 8] = an_n;
        end
      end
`ifdef SEG_LEADING_ZERO_BLANK_EN
      exp_code = t.cb;
`else
      exp_code = t.cp;
`endif
      chk($sformatf("table%0d_codes", i), 64'(cap_code), 64'(exp_code));
      chk($sformatf("table%0d_dpn", i), 64'(cap_dpn), 64'(t.dpn));
      chk($sformatf("table%0d_anodes", i), cap_an, 64'h7FBFDFEFF7FBFDFE);
    end

    repeat (640)
      step(($urandom % 150) != 0, ($urandom % 4) == 0, $urandom >> ($urandom % 32),
           ($urandom % 3 == 0) ? 8'($urandom) : 8'h0);

    step(1'b1, 1'b1, 32'h12345678, 8'h00);
    cnt = 0;
    while (!e_fd && cnt < 2 * FR) begin step(1'b1, 1'b0, 32'h0, 8'h0); cnt++; end
    cnt = 0;
    while (e_an !== 8'hDF && cnt < 2 * FR) begin step(1'b1, 1'b0, 32'h0, 8'h0); cnt++; end
    chk("midscan_digit5_code", 64'(digit_code), 64'h03);
    step(1'b0, 1'b0, 32'h0, 8'h0);
    chk("midscan_reset_an", 64'(an_n), 64'hFF);
    chk("midscan_reset_code", 64'(digit_code), 64'h10);
    chk("midscan_reset_dpn", 64'(dp_n), 64'h1);
    chk("midscan_reset_fd", 64'(frame_done), 64'h0);
    step(1'b1, 1'b0, 32'h0, 8'h0);
    chk("restart_dead_an", 64'(an_n), 64'hFF);
    step(1'b1, 1'b0, 32'h0, 8'h0);
    chk("restart_digit0_an", 64'(an_n), 64'hFE);
    chk("restart_digit0_code", 64'(digit_code), 64'h00);
    repeat (40) step(1'b1, 1'b0, 32'h0, 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
